// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: access-size encodings, FSM states and
// helpers that derive address-field widths from the cache geometry.
// Latency: n/a (definitions only). Backpressure: n/a.
package data_cache_pkg;

   // SizeCtr encodings
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic {S_IDLE, S_REFILL} state_t;

   // Byte-within-word field width
   function automatic int byte_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   // Word-within-line field width (also the refill counter width)
   function automatic int word_bits(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int offset_bits(input int data_width, input int words_per_line);
      return byte_bits(data_width) + word_bits(words_per_line);
   endfunction

   function automatic int index_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_bits(input int addr_width, input int data_width,
                                   input int sets, input int words_per_line);
      return addr_width - index_bits(sets) - offset_bits(data_width, words_per_line);
   endfunction

   // 011, 110 and 111 are not valid access sizes
   function automatic logic size_legal(input logic [2:0] sz);
      logic ok;
      case (sz)
         SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_cache_load_extend.sv
// Extracts a byte/halfword/word from a data word and sign- or zero-extends it.
// Latency: combinational. Backpressure: none.
// Ports: word_i (source word), off_i (byte offset in word), size_i (SizeCtr), data_o (result).
module load_extend
   import data_cache_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)(
   input  logic [DATA_WIDTH-1:0]             word_i,
   input  logic [byte_bits(DATA_WIDTH)-1:0]  off_i,
   input  logic [2:0]                        size_i,
   output logic [DATA_WIDTH-1:0]             data_o
);

   localparam int BYTE_W = byte_bits(DATA_WIDTH);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{off_i, 3'b000} +: 8];
      // halfword lane ignores offset bit 0; an aligned halfword never sets it
      half_sel = word_i[{off_i[BYTE_W-1:1], 4'b0000} +: 16];
      case (size_i)
         SZ_B:    data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         SZ_BU:   data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         SZ_H:    data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         SZ_HU:   data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         SZ_W:    data_o = word_i;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache for the memory stage.
// Latency: load hit / store / bypass 0 cycles; load miss stalls WORDS_PER_LINE cycles.
// Backpressure: Stall freezes the pipeline while a line refills; stores never stall.
// Ports: clk/rst; MemRead/MemWrite/SizeCtr/ALUResult/WriteData from the pipeline,
// ReadData/Stall back to it; Dm* is the combinational-read data memory port.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 17,
   parameter int SETS           = 64,
   parameter int WORDS_PER_LINE = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            SizeCtr,
   input  logic [ADDR_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  Stall,
   output logic [ADDR_WIDTH-1:0] DmAddr,
   output logic [2:0]            DmSize,
   output logic                  DmWrite,
   output logic [DATA_WIDTH-1:0] DmWData,
   input  logic [DATA_WIDTH-1:0] DmRData
);

   localparam int BYTE_W  = byte_bits(DATA_WIDTH);
   localparam int CNT_W   = word_bits(WORDS_PER_LINE);
   localparam int OFF_W   = offset_bits(DATA_WIDTH, WORDS_PER_LINE);
   localparam int IDX_W   = index_bits(SETS);
   localparam int TAG_W   = tag_bits(ADDR_WIDTH, DATA_WIDTH, SETS, WORDS_PER_LINE);
   localparam int NBYTES  = DATA_WIDTH / 8;
   localparam int LINES_W = IDX_W + CNT_W;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

   // Address fields
   logic [BYTE_W-1:0] byte_off;
   logic [CNT_W-1:0]  word_sel;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;

   assign byte_off = ALUResult[BYTE_W-1:0];
   assign word_sel = ALUResult[OFF_W-1:BYTE_W];
   assign idx      = ALUResult[OFF_W +: IDX_W];
   assign tag      = ALUResult[ADDR_WIDTH-1 -: TAG_W];

   // State
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TAG_W-1:0]  rtag_q, rtag_d;
   logic [IDX_W-1:0]  ridx_q, ridx_d;
   logic [SETS-1:0]   valid_q, valid_d;

   // Storage arrays (no reset: contents are qualified by valid_q)
   logic [TAG_W-1:0]      tag_ram  [SETS];
   logic [DATA_WIDTH-1:0] data_ram [SETS*WORDS_PER_LINE];

   // Array write port
   logic                  arr_we;
   logic [LINES_W-1:0]    arr_addr;
   logic [DATA_WIDTH-1:0] arr_wdata;
   logic [NBYTES-1:0]     arr_be;
   logic                  tag_we;

   // Request decode
   logic legal, is_store, is_load, misaligned, tag_match, hit;
   logic [DATA_WIDTH-1:0] cached_word;

   assign legal       = size_legal(SizeCtr);
   assign is_store    = MemWrite & legal;
   assign is_load     = MemRead & ~MemWrite & legal;
   assign misaligned  = ((SizeCtr[1:0] == 2'b10) && (byte_off != '0)) ||
                        ((SizeCtr[1:0] == 2'b01) && byte_off[0]);
   assign tag_match   = (tag_ram[idx] == tag);
   assign hit         = valid_q[idx] & tag_match;
   assign cached_word = data_ram[{idx, word_sel}];

   // Store lane placement: data replicated across lanes, byte enables pick the target
   logic [DATA_WIDTH-1:0] st_wdata;
   logic [NBYTES-1:0]     st_be;

   always_comb begin
      case (SizeCtr[1:0])
         2'b00: begin
            st_wdata = {NBYTES{WriteData[7:0]}};
            st_be    = NBYTES'(1) << byte_off;
         end
         2'b01: begin
            st_wdata = {(NBYTES/2){WriteData[15:0]}};
            st_be    = NBYTES'(3) << {byte_off[BYTE_W-1:1], 1'b0};
         end
         default: begin
            st_wdata = WriteData;
            st_be    = '1;
         end
      endcase
   end

   // Bypass loads take the memory's data, which already starts at the
   // requested byte, so no further lane shift is applied to it.
   logic [DATA_WIDTH-1:0] ext_word, ext_data;
   logic [BYTE_W-1:0]     ext_off;

   assign ext_word = misaligned ? DmRData : cached_word;
   assign ext_off  = misaligned ? '0 : byte_off;

   load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
      .word_i (ext_word),
      .off_i  (ext_off),
      .size_i (SizeCtr),
      .data_o (ext_data)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rtag_d    = rtag_q;
      ridx_d    = ridx_q;
      valid_d   = valid_q;
      Stall     = 1'b0;
      ReadData  = '0;
      DmAddr    = ALUResult;
      DmSize    = SizeCtr;
      DmWrite   = 1'b0;
      DmWData   = WriteData;
      arr_we    = 1'b0;
      arr_addr  = {idx, word_sel};
      arr_wdata = st_wdata;
      arr_be    = st_be;
      tag_we    = 1'b0;

      // Reset holds the bus idle and suppresses any array write
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               if (is_store) begin
                  DmWrite = 1'b1;
                  if (misaligned) begin
                     // a bypassed store would leave a stale cached copy
                     if (tag_match) valid_d[idx] = 1'b0;
                  end else if (hit) begin
                     arr_we = 1'b1;
                  end
               end else if (is_load) begin
                  if (misaligned || hit) begin
                     ReadData = ext_data;
                  end else begin
                     // The miss cycle already fetches word 0, so the total
                     // stall is exactly WORDS_PER_LINE cycles.
                     Stall     = 1'b1;
                     DmAddr    = {tag, idx, {OFF_W{1'b0}}};
                     DmSize    = SZ_W;
                     arr_we    = 1'b1;
                     arr_addr  = {idx, {CNT_W{1'b0}}};
                     arr_wdata = DmRData;
                     arr_be    = '1;
                     valid_d[idx] = 1'b0;
                     rtag_d    = tag;
                     ridx_d    = idx;
                     cnt_d     = CNT_W'(1);
                     state_d   = S_REFILL;
                  end
               end
            end
            S_REFILL: begin
               Stall     = 1'b1;
               DmAddr    = {rtag_q, ridx_q, cnt_q, {BYTE_W{1'b0}}};
               DmSize    = SZ_W;
               arr_we    = 1'b1;
               arr_addr  = {ridx_q, cnt_q};
               arr_wdata = DmRData;
               arr_be    = '1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LAST_WORD) begin
                  valid_d[ridx_q] = 1'b1;
                  tag_we  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rtag_q  <= '0;
         ridx_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rtag_q  <= rtag_d;
         ridx_q  <= ridx_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (arr_be[b]) data_ram[arr_addr][b*8 +: 8] <= arr_wdata[b*8 +: 8];
         end
      end
      if (tag_we) tag_ram[ridx_q] <= rtag_q;
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a byte-addressed data memory model.
// Latency: n/a. Backpressure: bench waits on Stall with a bounded loop.
module tb_data_cache;

   logic        clk, rst, MemRead, MemWrite;
   logic [2:0]  SizeCtr;
   logic [16:0] ALUResult;
   logic [31:0] WriteData, ReadData;
   logic        Stall;
   logic [16:0] DmAddr;
   logic [2:0]  DmSize;
   logic        DmWrite;
   logic [31:0] DmWData, DmRData;

   int n_assert = 0;
   int n_fail   = 0;

   data_cache dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
      .SizeCtr(SizeCtr), .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .Stall(Stall), .DmAddr(DmAddr), .DmSize(DmSize),
      .DmWrite(DmWrite), .DmWData(DmWData), .DmRData(DmRData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-addressed little-endian data memory, combinational read
   logic [7:0]  mem [0:131071];
   logic        preload;
   logic [16:0] pre_addr [5] = '{17'h10000, 17'h10004, 17'h10008, 17'h1000C, 17'h10400};
   logic [31:0] pre_dat  [5] = '{32'h8000_00FF, 32'h1122_3344, 32'h5566_7788,
                                 32'h99AA_BBCC, 32'h1357_9BDF};

   always_comb DmRData = {mem[DmAddr + 17'd3], mem[DmAddr + 17'd2],
                          mem[DmAddr + 17'd1], mem[DmAddr]};

   always @(posedge clk) begin
      if (preload) begin
         for (int w = 0; w < 5; w++)
            for (int b = 0; b < 4; b++)
               mem[pre_addr[w] + 17'(b)] <= pre_dat[w][8*b +: 8];
      end else if (DmWrite) begin
         mem[DmAddr] <= DmWData[7:0];
         if (DmSize[1:0] != 2'b00) mem[DmAddr + 17'd1] <= DmWData[15:8];
         if (DmSize[1:0] == 2'b10) begin
            mem[DmAddr + 17'd2] <= DmWData[23:16];
            mem[DmAddr + 17'd3] <= DmWData[31:24];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // Issue a load, count stalled cycles (bounded), then check the data
   task automatic do_load(input string name, input logic [16:0] addr, input logic [2:0] size,
                          input logic [31:0] exp_data, input int exp_stall);
      int n;
      MemRead = 1'b1; MemWrite = 1'b0; SizeCtr = size; ALUResult = addr;
      n = 0;
      @(negedge clk);
      while (Stall && n < 12) begin
         n++;
         @(negedge clk);
      end
      chk({name, " stall"}, n, exp_stall);
      chk({name, " data"}, ReadData, exp_data);
      @(posedge clk); #1;
      MemRead = 1'b0;
   endtask

   task automatic do_store(input string name, input logic [16:0] addr, input logic [2:0] size,
                           input logic [31:0] data);
      MemRead = 1'b0; MemWrite = 1'b1; SizeCtr = size; ALUResult = addr; WriteData = data;
      @(negedge clk);
      chk({name, " stall"}, Stall, 0);
      chk({name, " dmwrite"}, DmWrite, 1);
      chk({name, " dmaddr"}, DmAddr, addr);
      @(posedge clk); #1;
      MemWrite = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; preload = 1'b1;
      MemRead = 1'b0; MemWrite = 1'b0; SizeCtr = 3'b010; ALUResult = '0; WriteData = '0;
      @(posedge clk); #1;
      preload = 1'b0;
      @(negedge clk);
      chk("reset stall", Stall, 0);
      chk("reset dmwrite", DmWrite, 0);
      chk("reset readdata", ReadData, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Cold miss then hits with every extension mode
      do_load("lw miss",   17'h10000, 3'b010, 32'h8000_00FF, 4);
      do_load("lw hit",    17'h10000, 3'b010, 32'h8000_00FF, 0);
      do_load("lb",        17'h10000, 3'b000, 32'hFFFF_FFFF, 0);
      do_load("lbu",       17'h10000, 3'b100, 32'h0000_00FF, 0);
      do_load("lh",        17'h10002, 3'b001, 32'hFFFF_8000, 0);
      do_load("lhu",       17'h10002, 3'b101, 32'h0000_8000, 0);
      do_load("lw word3",  17'h1000C, 3'b010, 32'h99AA_BBCC, 0);
      do_load("lb byte2",  17'h10006, 3'b000, 32'h0000_0022, 0);
      do_load("lhu upper", 17'h1000A, 3'b101, 32'h0000_5566, 0);

      // Store hits update the cached copy
      do_store("sb hit", 17'h10001, 3'b000, 32'h0000_00A5);
      do_load("lw after sb", 17'h10000, 3'b010, 32'h8000_A5FF, 0);
      do_store("sh hit", 17'h1000E, 3'b001, 32'h0000_BEEF);
      do_load("lw after sh", 17'h1000C, 3'b010, 32'hBEEF_BBCC, 0);
      do_load("lh after sh", 17'h1000E, 3'b001, 32'hFFFF_BEEF, 0);

      // Illegal sizes: no access
      MemRead = 1'b1; SizeCtr = 3'b011; ALUResult = 17'h10000;
      @(negedge clk);
      chk("illegal ld stall", Stall, 0);
      chk("illegal ld data", ReadData, 0);
      chk("illegal ld dmwrite", DmWrite, 0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b1; SizeCtr = 3'b110; WriteData = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("illegal st dmwrite", DmWrite, 0);
      chk("illegal st stall", Stall, 0);
      @(posedge clk); #1;
      MemWrite = 1'b0;
      do_load("lw after illegal", 17'h10000, 3'b010, 32'h8000_A5FF, 0);

      // Read and write together act as a store
      MemRead = 1'b1; MemWrite = 1'b1; SizeCtr = 3'b010; ALUResult = 17'h10008;
      WriteData = 32'h5566_7788;
      @(negedge clk);
      chk("rw readdata", ReadData, 0);
      chk("rw dmwrite", DmWrite, 1);
      chk("rw stall", Stall, 0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;

      // Misaligned accesses bypass; misaligned store invalidates the line
      do_load("lw misaligned", 17'h10005, 3'b010, 32'h8811_2233, 0);
      do_store("sw misaligned", 17'h10002, 3'b010, 32'hDEAD_BEEF);
      do_load("lw after mis sw", 17'h10000, 3'b010, 32'hBEEF_A5FF, 4);

      // No write allocate, then eviction by other tags on index 0
      do_store("sw uncached", 17'h12000, 3'b010, 32'hCAFE_F00D);
      do_load("lw 12000", 17'h12000, 3'b010, 32'hCAFE_F00D, 4);
      do_load("lw 10000 evicted", 17'h10000, 3'b010, 32'hBEEF_A5FF, 4);
      do_load("lw 10400", 17'h10400, 3'b010, 32'h1357_9BDF, 4);

      // Reset during the second refill cycle aborts the fill
      MemRead = 1'b1; MemWrite = 1'b0; SizeCtr = 3'b010; ALUResult = 17'h10000;
      @(negedge clk);
      chk("abort miss stall", Stall, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort stall drop", Stall, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_load("lw after abort", 17'h10000, 3'b010, 32'hBEEF_A5FF, 4);
      do_load("lw hit after abort", 17'h10000, 3'b010, 32'hBEEF_A5FF, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
